// File: rtl/axi_dma_req_gen_if.sv
// Command and sub-request channels of the DMA request generator.
// The master modport is the generator side; slave is the command source / request sink.
interface axi_dma_req_gen_if #(
  parameter int AW    = 32,
  parameter int TOT_W = 32,
  parameter int BC_W  = 13
) ();
  logic             cmd_valid;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_addr;
  logic [TOT_W-1:0] cmd_bytes;
  logic             cmd_fixed;

  logic             req_valid;
  logic             req_ready;
  logic [AW-1:0]    req_addr;
  logic [BC_W-1:0]  req_byte_len;
  logic             req_fixed;
  logic             req_lock;
  logic             req_resp_valid;
  logic [1:0]       req_resp;

  modport master (
    input  cmd_valid, cmd_addr, cmd_bytes, cmd_fixed,
    output cmd_ready,
    output req_valid, req_addr, req_byte_len, req_fixed, req_lock,
    input  req_ready, req_resp_valid, req_resp
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_bytes, cmd_fixed,
    input  cmd_ready,
    input  req_valid, req_addr, req_byte_len, req_fixed, req_lock,
    output req_ready, req_resp_valid, req_resp
  );
endinterface

// File: rtl/axi_dma_req_gen.sv
// Splits one DMA transfer command into sub-requests of at most MAX_REQ_BYTES that never
// cross a 4 KB boundary, limits in-flight sub-requests and reports done/error/abort.
module axi_dma_req_gen #(
  parameter int AW              = 32,
  parameter int TOT_W           = 32,
  parameter int BC_W            = 13,
  parameter int MAX_REQ_BYTES   = 256,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                clk,
  input  logic                rst,
  axi_dma_req_gen_if.master   bus,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic                aborted,
  output logic [1:0]          err_resp
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [TOT_W-1:0] MAX_REQ_T = TOT_W'(MAX_REQ_BYTES);
  localparam logic [3:0]       MAX_OUT_T = 4'(MAX_OUTSTANDING);

  state_t           state_r;
  logic             cmd_ready_r;
  logic             busy_r;
  logic             done_r;
  logic             error_r;
  logic             aborted_r;
  logic [1:0]       err_resp_r;
  logic [AW-1:0]    addr_r;
  logic [TOT_W-1:0] rem_r;
  logic             fixed_r;
  logic [3:0]       outst_r;
  logic             req_valid_r;
  logic [AW-1:0]    req_addr_r;
  logic [BC_W-1:0]  req_len_r;

  logic             hs_s;
  logic             resp_s;
  logic             err_new_s;
  logic             stop_s;
  logic             free_s;
  logic             can_issue_s;
  logic             cmd_bad_s;
  logic [AW-1:0]    addr_n_s;
  logic [TOT_W-1:0] rem_n_s;
  logic [3:0]       outst_n_s;
  logic [BC_W-1:0]  next_len_s;
  logic [BC_W-1:0]  cmd_len_s;

  // Largest chunk allowed from a byte address given the bytes still to move.
  function automatic logic [BC_W-1:0] chunk_len(input logic [11:0] a_lo,
                                                input logic [TOT_W-1:0] r,
                                                input logic f);
    logic [TOT_W-1:0] bnd;
    logic [TOT_W-1:0] lim;
    bnd = TOT_W'(13'd4096 - {1'b0, a_lo});
    lim = (!f && (bnd < MAX_REQ_T)) ? bnd : MAX_REQ_T;
    chunk_len = (r < lim) ? BC_W'(r) : BC_W'(lim);
  endfunction

  // Next-cycle bookkeeping: remaining bytes, address, outstanding count and issue permission.
  always_comb begin
    hs_s      = req_valid_r & bus.req_ready;
    resp_s    = bus.req_resp_valid & (outst_r != 4'd0);
    err_new_s = resp_s & bus.req_resp[1];
    stop_s    = abort | error_r | err_new_s;
    free_s    = ~req_valid_r | bus.req_ready;
    rem_n_s   = rem_r;
    addr_n_s  = addr_r;
    if (hs_s) begin
      rem_n_s = rem_r - TOT_W'(req_len_r);
      if (!fixed_r) begin
        addr_n_s = addr_r + AW'(req_len_r);
      end else begin
        addr_n_s = addr_r;
      end
    end else begin
      rem_n_s  = rem_r;
      addr_n_s = addr_r;
    end
    // A response with no request in flight is dropped so the counter cannot underflow.
    case ({hs_s, resp_s})
      2'b10:   outst_n_s = outst_r + 4'd1;
      2'b01:   outst_n_s = outst_r - 4'd1;
      default: outst_n_s = outst_r;
    endcase
    can_issue_s = (rem_n_s != '0) && (outst_n_s < MAX_OUT_T) && !stop_s;
    next_len_s  = chunk_len(addr_n_s[11:0], rem_n_s, fixed_r);
    cmd_len_s   = chunk_len(bus.cmd_addr[11:0], bus.cmd_bytes, bus.cmd_fixed);
    cmd_bad_s   = (bus.cmd_addr[1:0] != 2'b00) | (bus.cmd_bytes[1:0] != 2'b00) |
                  (bus.cmd_bytes == '0);
  end

  // Control FSM with all externally visible outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      aborted_r   <= 1'b0;
      err_resp_r  <= 2'd0;
      addr_r      <= '0;
      rem_r       <= '0;
      fixed_r     <= 1'b0;
      outst_r     <= 4'd0;
      req_valid_r <= 1'b0;
      req_addr_r  <= '0;
      req_len_r   <= '0;
    end else begin
      done_r  <= 1'b0;
      outst_r <= outst_n_s;
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid) begin
            addr_r      <= bus.cmd_addr;
            rem_r       <= bus.cmd_bytes;
            fixed_r     <= bus.cmd_fixed;
            aborted_r   <= 1'b0;
            cmd_ready_r <= 1'b0;
            busy_r      <= 1'b1;
            if (cmd_bad_s) begin
              error_r    <= 1'b1;
              err_resp_r <= 2'd2;
              state_r    <= ST_DONE;
            end else begin
              error_r     <= 1'b0;
              err_resp_r  <= 2'd0;
              req_valid_r <= 1'b1;
              req_addr_r  <= bus.cmd_addr;
              req_len_r   <= cmd_len_s;
              state_r     <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          addr_r <= addr_n_s;
          rem_r  <= rem_n_s;
          if (abort) begin
            aborted_r <= 1'b1;
          end
          if (err_new_s) begin
            error_r <= 1'b1;
            if (!error_r) begin
              err_resp_r <= bus.req_resp;
            end
          end
          // A presented request is held until accepted; stops only apply between requests.
          if (free_s) begin
            req_valid_r <= can_issue_s;
            req_addr_r  <= addr_n_s;
            req_len_r   <= next_len_s;
            if ((rem_n_s == '0) || stop_s) begin
              state_r <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            aborted_r <= 1'b1;
          end
          if (err_new_s) begin
            error_r <= 1'b1;
            if (!error_r) begin
              err_resp_r <= bus.req_resp;
            end
          end
          if (outst_r == 4'd0) begin
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_r      <= 1'b1;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          state_r     <= ST_IDLE;
          req_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready    = cmd_ready_r;
  assign bus.req_valid    = req_valid_r;
  assign bus.req_addr     = req_addr_r;
  assign bus.req_byte_len = req_len_r;
  assign bus.req_fixed    = fixed_r;
  assign bus.req_lock     = 1'b0;
  assign busy             = busy_r;
  assign done             = done_r;
  assign error            = error_r;
  assign aborted          = aborted_r;
  assign err_resp         = err_resp_r;

endmodule

// File: tb/tb_axi_dma_req_gen.sv
// Randomized bench for axi_dma_req_gen: expected sub-request lists, error and abort
// outcomes come from a chunk-list model built directly from the transfer rules.
module tb_axi_dma_req_gen;
  localparam int AW = 32, TOT_W = 32, BC_W = 13, MAXB = 256, MAXO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       busy, done, error, aborted;
  logic [1:0] err_resp;

  axi_dma_req_gen_if #(.AW(AW), .TOT_W(TOT_W), .BC_W(BC_W)) bus ();

  axi_dma_req_gen #(.AW(AW), .TOT_W(TOT_W), .BC_W(BC_W),
                    .MAX_REQ_BYTES(MAXB), .MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst), .bus(bus), .abort(abort), .busy(busy), .done(done),
    .error(error), .aborted(aborted), .err_resp(err_resp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state for the current command
  logic [31:0] exp_addr_q[$];
  int          exp_len_q[$];
  bit          exp_fixed, bad_cmd, exp_aborted, model_err, stopped, prev_valid, prev_hs;
  bit [1:0]    model_code, err_code;
  int          inflight, hs_total, resp_idx, err_idx, abort_at, lat, same_cnt;

  task automatic build_model(input logic [31:0] a, input logic [31:0] b, input bit f);
    longint r, cur, c;
    exp_addr_q.delete();
    exp_len_q.delete();
    bad_cmd = (a % 4 != 0) || (b % 4 != 0) || (b == 0);
    r = bad_cmd ? 0 : b;
    cur = a;
    while (r > 0) begin
      c = (r > MAXB) ? MAXB : r;
      if (!f && (4096 - (cur % 4096)) < c) c = 4096 - (cur % 4096);
      exp_addr_q.push_back(32'(cur));
      exp_len_q.push_back(int'(c));
      r -= c;
      if (!f) cur = (cur + c) % 64'h1_0000_0000;
    end
  endtask

  task automatic start_cmd(input logic [31:0] a, input logic [31:0] b, input bit f, input int ab_at);
    build_model(a, b, f);
    exp_fixed = f; inflight = 0; hs_total = 0; resp_idx = 0; model_err = 0; model_code = 2'd0;
    stopped = 0; prev_valid = 0; prev_hs = 0; abort_at = ab_at;
    exp_aborted = (ab_at >= 0) && !bad_cmd;
    check_eq("cmd_ready_idle", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1; bus.cmd_addr = a; bus.cmd_bytes = b; bus.cmd_fixed = f;
    bus.req_ready = 1'b0; bus.req_resp_valid = 1'b0;
    abort = (ab_at == 0);
    @(posedge clk); @(negedge clk);
    bus.cmd_valid = 1'b0; bus.cmd_addr = $urandom; bus.cmd_bytes = $urandom; bus.cmd_fixed = ~f;
    lat = 1;
    check_eq("busy_after_accept", busy, 1'b1);
    check_eq("cmd_ready_busy", bus.cmd_ready, 1'b0);
  endtask

  // One clock: decide ready/response, check any handshake against the model, advance.
  task automatic step(input bit rdy, input bit rv_in);
    bit [1:0] code;
    bit rv, hs, v0, stop_now, ab;
    rv   = rv_in && (inflight > 0);
    code = (resp_idx == err_idx) ? err_code : 2'($urandom_range(0, 1));
    v0   = bus.req_valid;
    if (stopped && v0) check_eq("issue_after_stop", v0 && (!prev_valid || prev_hs), 1'b0);
    hs = v0 && rdy;
    if (hs) begin
      check_eq("req_in_model", exp_addr_q.size() != 0, 1'b1);
      if (exp_addr_q.size() != 0) begin
        check_eq("req_addr", bus.req_addr, exp_addr_q.pop_front());
        check_eq("req_byte_len", bus.req_byte_len, exp_len_q.pop_front());
        check_eq("req_fixed", bus.req_fixed, exp_fixed);
      end
      inflight++; hs_total++;
    end
    if (rv) begin
      if (code[1] && !model_err) begin model_err = 1; model_code = code; end
      inflight--; resp_idx++;
      if (hs) same_cnt++;
    end
    if (hs) check_eq("outstanding_limit", inflight <= MAXO, 1'b1);
    ab = (abort_at >= 0) && (lat >= abort_at);
    stop_now = (rv && code[1]) || ab;
    bus.req_ready = rdy; bus.req_resp_valid = rv; bus.req_resp = code; abort = ab;
    @(posedge clk); @(negedge clk);
    prev_valid = v0; prev_hs = hs; lat++;
    if (stop_now) stopped = 1;
  endtask

  task automatic finish_cmd(input int rdy_pct, input int resp_pct);
    bit eerr;
    bit [1:0] ecode;
    while (!done && lat < 3000)
      step(($urandom % 100) < rdy_pct, ($urandom % 100) < resp_pct);
    check_eq("done_seen", done, 1'b1);
    eerr  = bad_cmd ? 1'b1 : model_err;
    ecode = bad_cmd ? 2'd2 : model_code;
    check_eq("error", error, eerr);
    check_eq("err_resp", err_resp, ecode);
    check_eq("aborted", aborted, exp_aborted);
    check_eq("drained", inflight, 0);
    if (!stopped) check_eq("all_issued", exp_addr_q.size(), 0);
    if (bad_cmd) check_eq("bad_cmd_done_latency", lat, 2);
    abort = 1'b0; bus.req_ready = 1'b0; bus.req_resp_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check_eq("done_one_cycle", done, 1'b0);
    check_eq("idle_not_busy", busy, 1'b0);
  endtask

  task automatic run_cmd(input logic [31:0] a, input logic [31:0] b, input bit f, input int ab_at,
                         input int rdy_pct, input int resp_pct);
    start_cmd(a, b, f, ab_at);
    finish_cmd(rdy_pct, resp_pct);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cmd_ready"}, bus.cmd_ready, 1'b1);
    check_eq({tag, "_req_valid"}, bus.req_valid, 1'b0);
    check_eq({tag, "_req_addr"}, bus.req_addr, 0);
    check_eq({tag, "_req_len"}, bus.req_byte_len, 0);
    check_eq({tag, "_req_fixed"}, bus.req_fixed, 1'b0);
    check_eq({tag, "_req_lock"}, bus.req_lock, 1'b0);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_done"}, done, 1'b0);
    check_eq({tag, "_error"}, error, 1'b0);
    check_eq({tag, "_aborted"}, aborted, 1'b0);
    check_eq({tag, "_err_resp"}, err_resp, 2'd0);
  endtask

  initial begin
    logic [31:0] ra, rb;
    rst = 1'b1; abort = 1'b0; err_idx = -1; err_code = 2'd2; same_cnt = 0;
    bus.cmd_valid = 1'b0; bus.cmd_addr = '0; bus.cmd_bytes = '0; bus.cmd_fixed = 1'b0;
    bus.req_ready = 1'b0; bus.req_resp_valid = 1'b0; bus.req_resp = 2'd0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    check_reset_outputs("reset");

    run_cmd(32'h1000, 32'h300, 1'b0, -1, 100, 100);
    run_cmd(32'h0FC0, 32'h100, 1'b0, -1, 70, 60);
    run_cmd(32'h2000, 32'h208, 1'b1, -1, 100, 50);

    // Outstanding limit with responses withheld, then one released, then overlapping traffic
    start_cmd(32'h0, 32'h1000, 1'b0, -1);
    repeat (10) step(1'b1, 1'b0);
    check_eq("limit_handshakes", hs_total, MAXO);
    check_eq("limit_valid_low", bus.req_valid, 1'b0);
    step(1'b1, 1'b1);
    repeat (5) step(1'b1, 1'b0);
    check_eq("limit_one_more", hs_total, MAXO + 1);
    same_cnt = 0;
    finish_cmd(100, 100);
    check_eq("same_cycle_resp_and_req", same_cnt > 0, 1'b1);

    err_idx = 1; err_code = 2'd2;
    run_cmd(32'h3000, 32'h400, 1'b0, -1, 100, 80);
    err_idx = -1;

    run_cmd(32'h1002, 32'h40, 1'b0, 0, 100, 100);
    run_cmd(32'h1000, 32'h42, 1'b0, -1, 100, 100);
    run_cmd(32'h1000, 32'h0, 1'b0, -1, 100, 100);

    // Reset in the middle of issuing, followed by stray responses
    start_cmd(32'h4000, 32'h800, 1'b0, -1);
    step(1'b1, 1'b0); step(1'b0, 1'b0);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk); @(negedge clk); rst = 1'b0;
    bus.req_resp_valid = 1'b1; bus.req_resp = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      check_eq("no_done_after_reset", done, 1'b0);
      check_eq("stray_resp_no_error", error, 1'b0);
    end
    bus.req_resp_valid = 1'b0;
    run_cmd(32'h5000, 32'h200, 1'b0, -1, 100, 100);

    run_cmd(32'h8000, 32'h2000, 1'b0, 1, 50, 50);

    for (int k = 0; k < 24; k++) begin
      ra = {$urandom_range(0, 32'hFFFFF), 12'h000} | 32'($urandom_range(0, 1023) * 4);
      rb = 32'($urandom_range(1, 1536) * 4);
      err_idx  = ($urandom % 4 == 0) ? int'($urandom_range(0, 5)) : -1;
      err_code = ($urandom % 2 == 0) ? 2'd2 : 2'd3;
      run_cmd(ra, rb, 1'($urandom % 2), ($urandom % 5 == 0) ? int'($urandom_range(0, 2)) : -1,
              int'($urandom_range(30, 100)), int'($urandom_range(20, 100)));
    end
    err_idx = -1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/axi_dma_req_gen.md
Name: axi_dma_req_gen

Overview:
- Upstream stage of the DMA internal request path. Accepts one whole-transfer command (start address, total byte count, fixed/incrementing) and chops it into a sequence of sub-requests on the internal DMA request channel.
- Each sub-request is at most MAX_REQ_BYTES and never crosses a 4 KB boundary.
- Tracks outstanding sub-requests, collects their responses, and reports completion, error or abort.

Parameters:
- AW, 32: address width.
- TOT_W, 32: width of the total transfer byte count.
- BC_W, 13: width of req_byte_len; must hold 4096.
- MAX_REQ_BYTES, 256: maximum bytes per sub-request. Power of two, 4..4096, multiple of 4.
- MAX_OUTSTANDING, 4: maximum sub-requests issued but not yet responded to. Range 1..15.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- cmd_valid  in  1  command valid.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready.
- cmd_addr  in  AW  start byte address.
- cmd_bytes  in  TOT_W  total byte count.
- cmd_fixed  in  1  1 = fixed address, 0 = incrementing.
- abort  in  1  level; stop issuing new sub-requests.
- req_valid  out  1  sub-request valid.
- req_ready  in  1  sub-request accepted.
- req_addr  out  AW  sub-request address.
- req_byte_len  out  BC_W  sub-request byte count.
- req_fixed  out  1  copy of the latched cmd_fixed.
- req_lock  out  1  tied 0.
- req_resp_valid  in  1  one response per issued sub-request.
- req_resp  in  2  AXI response code: 0 OKAY, 1 EXOKAY, 2 SLVERR, 3 DECERR.
- busy  out  1  high when not IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky per command; cleared on next command accept.
- aborted  out  1  sticky per command; cleared on next command accept.
- err_resp  out  2  first error response code of the command.

Behaviour:

Reset:
- All outputs 0 and state IDLE, except cmd_ready = 1.
- Outstanding counter, remaining-byte count and current address are cleared.
- Reset mid-transfer drops the transfer with no done pulse. Responses arriving after reset find the counter at 0 and are ignored.

States IDLE, ISSUE, DRAIN, DONE:
- IDLE: cmd_ready = 1. On command handshake, latch addr, bytes and fixed; clear error, aborted and err_resp.
  - If cmd_addr[1:0] != 0, cmd_bytes[1:0] != 0, or cmd_bytes == 0: set error = 1, err_resp = 2, go to DONE. No sub-request is issued.
  - Otherwise go to ISSUE.
- ISSUE: req_valid = 1 while remaining > 0, outstanding < MAX_OUTSTANDING, and no stop condition holds.
  - Chunk when incrementing: min(remaining, MAX_REQ_BYTES, 4096 - addr[11:0]).
  - Chunk when fixed: min(remaining, MAX_REQ_BYTES).
  - On handshake: remaining -= chunk; addr += chunk if incrementing; outstanding += 1.
  - Go to DRAIN when remaining reaches 0, on error, or on abort.
- DRAIN: req_valid = 0. When outstanding == 0, go to DONE.
- DONE: done = 1 for exactly one cycle, then IDLE.

Handshake rules:
- Once req_valid is asserted, req_valid, req_addr, req_byte_len and req_fixed are held stable until req_ready.
- A stop condition (abort or error) takes effect only when req_valid is low or in the handshake cycle. A request already presented completes its handshake first.
- req_addr and req_byte_len are registered; there is no combinational path from req_ready to them.
- First sub-request: req_valid asserts the cycle after command accept.
- Back-to-back sub-requests are allowed every cycle while req_ready is high and the outstanding limit permits.

Outstanding counter:
- Handshake and req_resp_valid in the same cycle: net change 0. A request can still issue in that cycle even when at the limit before the response.
- req_resp_valid while the counter is 0: ignored, counter stays 0.

Error:
- Any response with req_resp[1] = 1 sets error. The first such code is captured in err_resp; later codes are ignored.
- No further sub-requests are issued after an error.
- EXOKAY is treated as success.

Abort:
- Sets aborted (sticky) in ISSUE or DRAIN.
- Ignored in IDLE and DONE.

Test Plan:
1. addr 0x1000, bytes 0x300, incr, OKAY responses -> sub-requests 0x1000/0x100, 0x1100/0x100, 0x1200/0x100; done pulse after the 3rd response; error = 0.
2. 4 KB crossing: addr 0x0FC0, bytes 0x100 -> 0x0FC0/0x40 then 0x1000/0xC0.
3. Fixed: addr 0x2000, bytes 0x208 -> 0x2000/0x100, 0x2000/0x100, 0x2000/0x8, all with req_fixed = 1.
4. Outstanding limit: bytes 0x1000, req_ready held 1, responses withheld -> exactly 4 handshakes, then req_valid low. Release one response -> exactly one more handshake. Also cover response and handshake in the same cycle.
5. Error: 2nd response SLVERR on a 0x400 transfer -> no new sub-requests after the in-flight ones; drain; done with error = 1, err_resp = 2.
6. Misaligned cmd_addr 0x1002 -> zero sub-requests; done 2 cycles after accept; error = 1. Separately, assert rst mid-ISSUE -> all outputs at reset values immediately, no done pulse.
